// File: rtl/float_pkg.sv
// Shared constants and FSM state encoding for the float datapath
// (int-to-float converter and the float multiplier path).
package float_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/float_round_rne.sv
// Round-to-nearest-even of a normalised magnitude into packed exp/frac.
// The hidden bit is implicit; a frac carry ripples into the exponent.
module float_round_rne
  import float_pkg::*;
(
  input  logic [30:0]                   mag_i,
  input  logic [FP_EXP_W-1:0]           exp_i,
  output logic [FP_EXP_W+FP_FRAC_W-1:0] packed_o
);

  logic [FP_FRAC_W-1:0] frac;
  logic                 guard;
  logic                 sticky;
  logic                 inc;

  always_comb begin
    frac     = mag_i[30:8];
    guard    = mag_i[7];
    sticky   = |mag_i[6:0];
    inc      = guard && (sticky || frac[0]);
    // Adding across the exp/frac boundary handles the all-ones carry.
    packed_o = {exp_i, frac} + {{(FP_EXP_W+FP_FRAC_W-1){1'b0}}, inc};
  end

endmodule

// File: rtl/int_to_float_converter.sv
// Iterative 32-bit integer to IEEE-754 single converter.
// Normalises one bit per clock, then rounds to nearest-even.
module int_to_float_converter
  import float_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1,
  parameter int BIAS      = FP_BIAS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam logic [FP_EXP_W-1:0] EXP_INIT = FP_EXP_W'(BIAS + 31);

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [31:0]         mag_q, mag_d;
  logic [FP_EXP_W-1:0] exp_q, exp_d;
  logic [31:0]         out_data_q, out_data_d;

  logic                neg_in;
  logic [31:0]         abs_in;
  logic [30:0]         rnd_packed;

  float_round_rne u_round (
    .mag_i    (mag_q[30:0]),
    .exp_i    (exp_q),
    .packed_o (rnd_packed)
  );

  // 0x8000_0000 negates to itself, which is the correct magnitude.
  assign neg_in = SIGNED_IN && in_data[31];
  assign abs_in = neg_in ? (32'd0 - in_data) : in_data;

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    out_data_d = out_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = neg_in;
          mag_d  = abs_in;
          exp_d  = EXP_INIT;
          if (abs_in == 32'd0) begin
            sign_d     = 1'b0;
            out_data_d = 32'h0000_0000;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        out_data_d = {sign_q, rnd_packed};
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sign_q     <= 1'b0;
      mag_q      <= 32'd0;
      exp_q      <= '0;
      out_data_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_int_to_float_converter.sv
// Directed bench for int_to_float_converter with an expected-result
// queue filled at accept time and drained when out_valid is seen.
module tb_int_to_float_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;

  logic        in_valid_u, in_ready_u, out_valid_u, out_ready_u;
  logic [31:0] in_data_u, out_data_u;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  int_to_float_converter #(.SIGNED_IN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int_to_float_converter #(.SIGNED_IN(1'b0)) dut_u (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_u),
    .in_ready  (in_ready_u),
    .in_data   (in_data_u),
    .out_valid (out_valid_u),
    .out_ready (out_ready_u),
    .out_data  (out_data_u)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic start(input logic [31:0] din, input logic [31:0] expd,
                       input int lat);
    exp_t e;
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_data  = din;
    in_valid = 1'b1;
    e.data = expd;
    e.lat  = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_out(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(n), 32'(e.lat));
    chk({tag, "_data"}, out_data, e.data);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_cleared"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic conv(input string tag, input logic [31:0] din,
                      input logic [31:0] expd, input int lat);
    start(din, expd, lat);
    wait_out(tag);
    take(tag);
  endtask

  initial begin
    logic [31:0] held;
    int          n;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 32'd0;
    out_ready   = 1'b0;
    in_valid_u  = 1'b0;
    in_data_u   = 32'd0;
    out_ready_u = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    conv("one", 32'd1, 32'h3F80_0000, 33);
    conv("five", 32'd5, 32'h40A0_0000, 31);
    conv("zero", 32'd0, 32'h0000_0000, 0);
    conv("minus_one", 32'hFFFF_FFFF, 32'hBF80_0000, 33);
    conv("int_min", 32'h8000_0000, 32'hCF00_0000, 2);
    conv("tie_even", 32'h0100_0003, 32'h4B80_0002, 9);
    conv("frac_carry", 32'h01FF_FFFF, 32'h4C00_0000, 9);
    conv("minus_1000", 32'hFFFF_FC18, 32'hC47A_0000, 24);

    // Backpressure: hold out_ready low and offer a competing input.
    start(32'd3, 32'h4040_0000, 32);
    wait_out("bp");
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'd7;
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", out_data, held);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take("bp");
    conv("after_bp", 32'd2, 32'h4000_0000, 32);

    // Reset during normalisation aborts the conversion.
    start(32'd1, 32'h3F80_0000, 33);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", out_data, 32'h0000_0000);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("abort_no_output", 32'(n), 32'd0);
    chk("abort_ready_after", 32'(in_ready), 32'd1);
    conv("after_abort", 32'd5, 32'h40A0_0000, 31);

    // Unsigned instance treats bit 31 as magnitude.
    @(negedge clk);
    in_valid_u = 1'b1;
    in_data_u  = 32'h8000_0000;
    @(posedge clk);
    #1;
    in_valid_u = 1'b0;
    n = 0;
    while (!out_valid_u && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("uns_latency", 32'(n), 32'd2);
    chk("uns_data", out_data_u, 32'h4F00_0000);
    @(negedge clk);
    out_ready_u = 1'b1;
    @(posedge clk);
    #1;
    out_ready_u = 1'b0;
    chk("uns_ready_back", 32'(in_ready_u), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
